// File: rtl/alu_issue_ctrl.sv
// Issue controller for the RF/ALU datapath. It accepts one R-type instruction,
// decodes it, and sequences RF read -> ALU execute/RF write -> done pulse.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE. An offer made
// while the controller is busy is not consumed and may be held until accepted.
module alu_issue_ctrl #(
   parameter bit ZERO_REG_PROTECT = 1'b0,
   parameter bit TRAP_OVF         = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   output logic [4:0]  rr1,
   output logic [4:0]  rr2,
   output logic [4:0]  wr,
   output logic [3:0]  op,
   output logic        mode,
   output logic [31:0] shift_amp,
   output logic        enable,
   output logic [1:0]  sel,
   output logic        done,
   output logic [31:0] result_out,
   output logic        ovf_out,
   output logic        illegal,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Latched instruction fields and decode results
   logic [4:0] rs_q, rt_q, rd_q, shamt_q;
   logic [3:0] op_q;
   logic       legal_q, shift_q, addsub_q;

   // Captured completion status
   logic [31:0] result_q, result_d;
   logic        ovf_q, ovf_d;
   logic        illegal_q, illegal_d;

   // Decode of the instruction currently offered
   logic [3:0] dec_op;
   logic       dec_legal, dec_shift, dec_addsub;
   logic       accept;
   logic       wen;

   assign accept    = instr_valid && (state_q == S_IDLE);
   assign dbg_state = state_q;

   // Combinational decode of opcode/funct into ALU opcode and class flags
   always_comb begin
      dec_op     = 4'b0000;
      dec_legal  = 1'b0;
      dec_shift  = 1'b0;
      dec_addsub = 1'b0;
      if (instr[31:26] == 6'd0) begin
         case (instr[5:0])
            6'h20: begin dec_legal = 1'b1; dec_op = 4'b0000; dec_addsub = 1'b1; end
            6'h22: begin dec_legal = 1'b1; dec_op = 4'b0001; dec_addsub = 1'b1; end
            6'h24: begin dec_legal = 1'b1; dec_op = 4'b0010; end
            6'h25: begin dec_legal = 1'b1; dec_op = 4'b0011; end
            6'h00: begin dec_legal = 1'b1; dec_op = 4'b0100; dec_shift = 1'b1; end
            6'h02: begin dec_legal = 1'b1; dec_op = 4'b0101; dec_shift = 1'b1; end
            6'h03: begin dec_legal = 1'b1; dec_op = 4'b0110; dec_shift = 1'b1; end
            6'h2C: begin dec_legal = 1'b1; dec_op = 4'b0111; end
            6'h2A: begin dec_legal = 1'b1; dec_op = 4'b1000; end
            default: ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Latch instruction fields and decode on the accept edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_q     <= 5'd0;
         rt_q     <= 5'd0;
         rd_q     <= 5'd0;
         shamt_q  <= 5'd0;
         op_q     <= 4'd0;
         legal_q  <= 1'b0;
         shift_q  <= 1'b0;
         addsub_q <= 1'b0;
      end else if (accept) begin
         rs_q     <= instr[25:21];
         rt_q     <= instr[20:16];
         rd_q     <= instr[15:11];
         shamt_q  <= instr[10:6];
         op_q     <= dec_op;
         legal_q  <= dec_legal;
         shift_q  <= dec_shift;
         addsub_q <= dec_addsub;
      end
   end

   // Completion status registers, updated at the closing edge of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= 32'd0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   // Write enable: legal, not a trapped add/sub overflow, not a protected r0
   assign wen = legal_q
              && !(TRAP_OVF && addsub_q && alu_overflow)
              && !(ZERO_REG_PROTECT && (rd_q == 5'd0));

   // Next state, status capture and datapath drives
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      illegal_d   = illegal_q;
      instr_ready = 1'b0;
      rr1         = 5'd0;
      rr2         = 5'd0;
      wr          = 5'd0;
      op          = 4'd0;
      mode        = 1'b0;
      shift_amp   = 32'd0;
      enable      = 1'b0;
      sel         = 2'd0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = S_READ;
         end
         S_READ: begin
            // Shifts operate on ALU operand A, so rt is routed to both ports
            rr1       = shift_q ? rt_q : rs_q;
            rr2       = rt_q;
            op        = op_q;
            mode      = 1'b1;
            shift_amp = {27'd0, shamt_q};
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            rr1       = shift_q ? rt_q : rs_q;
            rr2       = rt_q;
            op        = op_q;
            mode      = 1'b1;
            shift_amp = {27'd0, shamt_q};
            wr        = rd_q;
            sel       = 2'd1;
            enable    = wen;
            result_d  = alu_result;
            ovf_d     = addsub_q && alu_overflow;
            illegal_d = !legal_q;
            state_d   = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign result_out = result_q;
   assign ovf_out    = ovf_q;
   assign illegal    = illegal_q;

endmodule
